// File: rtl/compression_arbiter.sv
`default_nettype none
// ============================================================================
// compression_arbiter
//   Message-level round-robin arbiter sharing one 8-bit compressor port
//   between two valid/ready byte requesters, with a MAX_LEN cap per grant.
//   Revision: 1.0
// ============================================================================
module compression_arbiter #(
  parameter int MAX_LEN = 16,
  parameter int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] IN0_DATA,
  input  logic       IN0_VALID,
  input  logic       IN0_LAST,
  output logic       IN0_READY,
  input  logic [7:0] IN1_DATA,
  input  logic       IN1_VALID,
  input  logic       IN1_LAST,
  output logic       IN1_READY,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  output logic       OUT_LAST,
  output logic       OUT_TRUNC,
  output logic       OUT_SRC,
  input  logic       OUT_READY,
  output logic       BUSY
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [CW-1:0] C_CNT_MAX = CW'(MAX_LEN - 1);

  state_t        state_q, state_d;
  logic          own_q, own_d;
  logic          pri_q, pri_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          w_busy;
  logic          w_own_valid;
  logic          w_own_last;
  logic [7:0]    w_own_data;
  logic          w_at_max;
  logic          w_end;
  logic          w_xfer;

  always_comb begin
    w_busy      = (state_q == S_BUSY);
    w_own_valid = own_q ? IN1_VALID : IN0_VALID;
    w_own_last  = own_q ? IN1_LAST  : IN0_LAST;
    w_own_data  = own_q ? IN1_DATA  : IN0_DATA;
    w_at_max    = (cnt_q == C_CNT_MAX);
    w_end       = w_own_last | w_at_max;
    w_xfer      = w_busy & w_own_valid & OUT_READY;

    // Datapath is a pure pass-through of the owner while a grant is held.
    OUT_DATA    = w_busy ? w_own_data : 8'h00;
    OUT_VALID   = w_busy & w_own_valid;
    OUT_LAST    = OUT_VALID & w_end;
    OUT_TRUNC   = OUT_VALID & w_at_max & ~w_own_last;
    OUT_SRC     = w_busy & own_q;
    IN0_READY   = w_busy & ~own_q & OUT_READY;
    IN1_READY   = w_busy &  own_q & OUT_READY;
    BUSY        = w_busy;
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    pri_d   = pri_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (IN0_VALID | IN1_VALID) begin
          own_d   = (IN0_VALID & IN1_VALID) ? pri_q : IN1_VALID;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_xfer) begin
          if (w_end) begin
            state_d = S_IDLE;
            pri_d   = ~own_q;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      own_q   <= 1'b0;
      pri_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      pri_q   <= pri_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compression_arbiter.sv
`default_nettype none
// Testbench for compression_arbiter: randomized requesters, per-source
// expected-byte scoreboard and an arbitration-rule monitor.
module tb_compression_arbiter;

  localparam int MAX_LEN = 4;

  logic       CLK, RST_N;
  logic [7:0] IN0_DATA, IN1_DATA, OUT_DATA;
  logic       IN0_VALID, IN0_LAST, IN0_READY;
  logic       IN1_VALID, IN1_LAST, IN1_READY;
  logic       OUT_VALID, OUT_LAST, OUT_TRUNC, OUT_SRC, OUT_READY, BUSY;

  compression_arbiter #(.MAX_LEN(MAX_LEN)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN0_DATA(IN0_DATA), .IN0_VALID(IN0_VALID), .IN0_LAST(IN0_LAST), .IN0_READY(IN0_READY),
    .IN1_DATA(IN1_DATA), .IN1_VALID(IN1_VALID), .IN1_LAST(IN1_LAST), .IN1_READY(IN1_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST), .OUT_TRUNC(OUT_TRUNC),
    .OUT_SRC(OUT_SRC), .OUT_READY(OUT_READY), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Requester queues {last,data} and expected output queues {trunc,last,data}.
  logic [8:0] rq0[$], rq1[$];
  logic [9:0] eq0[$], eq1[$];
  int         pos0 = 0, pos1 = 0;
  logic       v0 = 1'b0, v1 = 1'b0;
  int         pv = 100, pr = 100;
  int         xfers0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected framing: a message ends at LAST or after MAX_LEN bytes of one grant.
  task automatic push_byte(input bit src, input logic [7:0] d, input logic l);
    int   p;
    logic el, et;
    p  = src ? pos1 : pos0;
    el = l || (p == MAX_LEN - 1);
    et = (p == MAX_LEN - 1) && !l;
    if (src) begin
      rq1.push_back({l, d}); eq1.push_back({et, el, d}); pos1 = el ? 0 : p + 1;
    end else begin
      rq0.push_back({l, d}); eq0.push_back({et, el, d}); pos0 = el ? 0 : p + 1;
    end
  endtask

  task automatic push_msg(input bit src, input int len);
    for (int i = 0; i < len; i++) push_byte(src, 8'($urandom), i == len - 1);
  endtask

  task automatic tick();
    logic a0, a1;
    @(negedge CLK);
    a0 = IN0_VALID & IN0_READY;
    a1 = IN1_VALID & IN1_READY;
    @(posedge CLK); #1;
    if (a0) begin rq0.delete(0); v0 = 1'b0; end
    if (a1) begin rq1.delete(0); v1 = 1'b0; end
    if (!v0 && rq0.size() > 0 && $urandom_range(99) < pv) v0 = 1'b1;
    if (!v1 && rq1.size() > 0 && $urandom_range(99) < pv) v1 = 1'b1;
    IN0_VALID = v0;
    {IN0_LAST, IN0_DATA} = v0 ? rq0[0] : 9'($urandom);
    IN1_VALID = v1;
    {IN1_LAST, IN1_DATA} = v1 ? rq1[0] : 9'($urandom);
    OUT_READY = ($urandom_range(99) < pr);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rq0.size() + rq1.size() + eq0.size() + eq1.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_complete", rq0.size() + rq1.size() + eq0.size() + eq1.size(), 0);
    repeat (3) tick();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {OUT_VALID, OUT_LAST, OUT_TRUNC, OUT_SRC, OUT_DATA, IN0_READY, IN1_READY, BUSY}, 0);
  endtask

  // Monitor: scoreboard pops on each transfer, plus arbitration-rule checks.
  initial begin : monitor
    logic pend_end, pend_grant, gexp, mpri, own;
    pend_end = 0; pend_grant = 0; gexp = 0; mpri = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        pend_end = 0; pend_grant = 0; mpri = 0;
      end else begin
        if (pend_end) chk("idle_after_last", BUSY, 0);
        if (pend_grant) begin
          chk("grant_latency", BUSY, 1);
          if (BUSY) chk("grant_src", OUT_SRC, gexp);
        end
        pend_end = 0; pend_grant = 0;
        if (BUSY) begin
          own = OUT_SRC;
          chk("owner_ready", own ? IN1_READY : IN0_READY, OUT_READY);
          chk("other_ready", own ? IN0_READY : IN1_READY, 0);
          chk("out_valid", OUT_VALID, own ? IN1_VALID : IN0_VALID);
          if (OUT_VALID && OUT_READY) begin
            if (own) begin
              if (eq1.size() == 0) chk("unexpected_byte_src1", 1, 0);
              else begin chk("xfer_src1", {OUT_TRUNC, OUT_LAST, OUT_DATA}, eq1[0]); eq1.delete(0); end
            end else begin
              xfers0++;
              if (eq0.size() == 0) chk("unexpected_byte_src0", 1, 0);
              else begin chk("xfer_src0", {OUT_TRUNC, OUT_LAST, OUT_DATA}, eq0[0]); eq0.delete(0); end
            end
            if (OUT_LAST) begin
              pend_end = 1;
              mpri = ~own;
            end
          end
        end else begin
          chk("idle_outputs", {OUT_VALID, OUT_LAST, OUT_TRUNC, OUT_SRC, OUT_DATA, IN0_READY, IN1_READY}, 0);
          if (IN0_VALID || IN1_VALID) begin
            pend_grant = 1;
            gexp = (IN0_VALID && IN1_VALID) ? mpri : IN1_VALID;
          end
        end
      end
    end
  end

  initial begin
    int base, n;
    RST_N = 1'b0; OUT_READY = 1'b0;
    IN0_VALID = 0; IN0_LAST = 0; IN0_DATA = 0;
    IN1_VALID = 0; IN1_LAST = 0; IN1_DATA = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("reset_values");
    RST_N = 1'b1;

    // Contention from reset: IN0 first, IN1 after one idle cycle.
    pv = 100; pr = 100;
    push_byte(0, 8'h20, 0); push_byte(0, 8'h42, 1);
    push_byte(1, 8'h69, 0); push_byte(1, 8'h74, 1);
    drain(100);

    // Single requester, three bytes.
    push_byte(0, 8'h42, 0); push_byte(0, 8'hAE, 0); push_byte(0, 8'h44, 1);
    drain(100);

    // Forced end at MAX_LEN: 0x40 truncates, 0x92 opens a new grant.
    push_byte(1, 8'h63, 0); push_byte(1, 8'h68, 0); push_byte(1, 8'hA5, 0);
    push_byte(1, 8'h40, 0); push_byte(1, 8'h92, 0); push_byte(1, 8'h11, 1);
    drain(100);

    // Fairness with continuous single-byte messages.
    for (int i = 0; i < 8; i++) begin push_msg(0, 1); push_msg(1, 1); end
    drain(200);

    // Backpressure and randomized traffic, including lengths beyond MAX_LEN.
    pr = 50;
    push_byte(0, 8'hA3, 0); push_byte(0, 8'h80, 1);
    drain(200);
    pv = 70; pr = 60;
    for (int i = 0; i < 150; i++) push_msg(1'($urandom), $urandom_range(1, 7));
    drain(20000);

    // Reset mid-message after 2 of 5 bytes.
    pv = 100; pr = 100;
    for (int i = 0; i < 5; i++) push_byte(0, 8'(8'h10 + i), i == 4);
    base = xfers0;
    n = 0;
    while (xfers0 < base + 2 && n < 100) begin tick(); n++; end
    chk("reset_phase_progress", xfers0 - base, 2);
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("mid_reset_values");
    rq0.delete(); rq1.delete(); eq0.delete(); eq1.delete();
    pos0 = 0; pos1 = 0; v0 = 0; v1 = 0;
    IN0_VALID = 0; IN1_VALID = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(0, 8'(8'h10 + i), i == 4);
    drain(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
